// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Registered EX-stage ALU for the multi-cycle CPU. Single-cycle ops
//   (AND/OR/ADD/SUB/SLT/SRL) complete at the accepting edge. MULTU
//   (shift-add) and DIVU (restoring) iterate one bit per cycle for WIDTH
//   cycles. A start/busy/done handshake lets the control FSM wait on done.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while busy=0
//   signal    op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 SRL,
//             100 MULTU, 101 DIVU
//   dataA     operand A
//   dataB     operand B (SRL source operand)
//   shamt     SRL shift amount
//   dataOut   result; MULTU low half; DIVU quotient
//   hi        MULTU high half; DIVU remainder; 0 for other ops
//   zero      dataOut == 0
//   overflow  signed overflow for ADD/SUB, 0 otherwise
//   busy      high while an iterative op runs
//   done      one-cycle pulse, outputs valid
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] hi_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    // Iteration state: hi_acc/lo_acc form the 2*WIDTH working register,
    // opnd holds the multiplicand (MULTU) or divisor (DIVU).
    logic [WIDTH-1:0] hi_acc_reg;
    logic [WIDTH-1:0] lo_acc_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             op_div_reg;
    logic [SHW-1:0]   cnt_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // SUB and SLT share the adder with B inverted and carry-in set.
    assign is_sub  = (signal == OP_SUB) || (signal == OP_SLT);
    assign b_eff   = is_sub ? ~dataB : dataB;
    assign sum     = dataA + b_eff + WIDTH'(is_sub);
    assign sum_ovf = (dataA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);

    // Logarithmic right shifter: stage gi shifts by 2**gi when shamt[gi] set.
    logic [WIDTH-1:0] shift_stage [0:SHW];
    assign shift_stage[0] = dataB;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_srl
            assign shift_stage[gi+1] = shamt[gi] ? (shift_stage[gi] >> (2**gi)) : shift_stage[gi];
        end
    endgenerate

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             is_iter_op;

    assign is_iter_op = (signal == OP_MULTU) || (signal == OP_DIVU);
    assign alu_ovf    = ((signal == OP_ADD) || (signal == OP_SUB)) ? sum_ovf : 1'b0;

    always_comb begin
        alu_result = '0;
        case (signal)
            OP_AND:  alu_result = dataA & dataB;
            OP_OR:   alu_result = dataA | dataB;
            OP_ADD:  alu_result = sum;
            OP_SUB:  alu_result = sum;
            OP_SLT:  alu_result = WIDTH'(sum[WIDTH-1] ^ sum_ovf);
            OP_SRL:  alu_result = shift_stage[SHW];
            default: alu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath (one bit per cycle)
    // ------------------------------------------------------------------
    // MULTU: lo_acc starts as the multiplier; each step conditionally adds
    // the multiplicand into the high half, then shifts the pair right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, hi_acc_reg} + (lo_acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], lo_acc_reg[WIDTH-1:1]};

    // DIVU: lo_acc starts as the dividend and fills with quotient bits from
    // the right; hi_acc is the partial remainder. A zero divisor always
    // "fits", which naturally yields an all-ones quotient and remainder=A.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign div_shift   = {hi_acc_reg, lo_acc_reg[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opnd_reg};
    assign div_ge      = div_shift >= {1'b0, opnd_reg};
    assign div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {lo_acc_reg[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign iter_hi = op_div_reg ? div_hi_next : mul_hi_next;
    assign iter_lo = op_div_reg ? div_lo_next : mul_lo_next;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            data_out_reg <= '0;
            hi_reg       <= '0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_acc_reg   <= '0;
            lo_acc_reg   <= '0;
            opnd_reg     <= '0;
            op_div_reg   <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    hi_acc_reg <= iter_hi;
                    lo_acc_reg <= iter_lo;
                    cnt_reg    <= cnt_reg + SHW'(1);
                    if (cnt_reg == SHW'(WIDTH - 1)) begin
                        data_out_reg <= iter_lo;
                        hi_reg       <= iter_hi;
                        zero_reg     <= (iter_lo == '0);
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= S_DONE;
                    end
                end
                default: begin
                    // S_IDLE and S_DONE both accept a new request.
                    if (start) begin
                        if (is_iter_op) begin
                            op_div_reg <= (signal == OP_DIVU);
                            hi_acc_reg <= '0;
                            lo_acc_reg <= (signal == OP_DIVU) ? dataA : dataB;
                            opnd_reg   <= (signal == OP_DIVU) ? dataB : dataA;
                            cnt_reg    <= '0;
                            busy_reg   <= 1'b1;
                            done_reg   <= 1'b0;
                            state_reg  <= S_RUN;
                        end else begin
                            data_out_reg <= alu_result;
                            hi_reg       <= '0;
                            zero_reg     <= (alu_result == '0);
                            overflow_reg <= alu_ovf;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= S_DONE;
                        end
                    end else begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign dataOut  = data_out_reg;
    assign hi       = hi_reg;
    assign zero     = zero_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Directed, table-driven bench for alu_multicycle (WIDTH=32) plus a small
//   WIDTH=8 instance. Latency is counted in clock edges from the edge that
//   accepts start (that edge = 1) until done is observed high.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;
    localparam int         MAX_CYC  = 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  signal;
    logic [31:0] dataA, dataB, dataOut, hi;
    logic [4:0]  shamt;
    logic        zero, overflow, busy, done;

    logic        start8;
    logic [2:0]  signal8;
    logic [7:0]  dataA8, dataB8, dataOut8, hi8;
    logic [2:0]  shamt8;
    logic        zero8, overflow8, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    alu_multicycle #(.WIDTH(32), .SHW(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signal(signal),
        .dataA(dataA), .dataB(dataB), .shamt(shamt),
        .dataOut(dataOut), .hi(hi), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done)
    );

    alu_multicycle #(.WIDTH(8), .SHW(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signal(signal8),
        .dataA(dataA8), .dataB(dataB8), .shamt(shamt8),
        .dataOut(dataOut8), .hi(hi8), .zero(zero8), .overflow(overflow8),
        .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        logic [31:0] exp_hi;
        logic        exp_zero;
        logic        exp_ovf;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request on the 32-bit DUT and wait for done. Operand inputs
    // are scrambled right after acceptance so any late sampling shows up.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int cycles, output int busy_cnt);
        @(negedge clk);
        signal = op; dataA = a; dataB = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataA = ~a; dataB = ~b; shamt = ~sh; signal = OP_AND;
        cycles = 1; busy_cnt = 0;
        while (!done && cycles < MAX_CYC) begin
            busy_cnt += int'(busy);
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: done not seen within %0d cycles", MAX_CYC);
        end
    endtask

    initial begin
        int cyc, bcnt, t;

        vecs[0]  = '{"add_ovf",   OP_ADD,   32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0, 1'b0, 1'b1, 1,  0};
        vecs[1]  = '{"sub_zero",  OP_SUB,   32'd5,        32'd5,        5'd0,  32'h00000000, 32'h0, 1'b1, 1'b0, 1,  0};
        vecs[2]  = '{"slt_true",  OP_SLT,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 32'h0, 1'b0, 1'b0, 1,  0};
        vecs[3]  = '{"srl_31",    OP_SRL,   32'h0,        32'h80000000, 5'd31, 32'h00000001, 32'h0, 1'b0, 1'b0, 1,  0};
        vecs[4]  = '{"and",       OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 32'h0, 1'b0, 1'b0, 1,  0};
        vecs[5]  = '{"or",        OP_OR,    32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 32'h0, 1'b0, 1'b0, 1,  0};
        vecs[6]  = '{"sub_ovf",   OP_SUB,   32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1,  0};
        vecs[7]  = '{"multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 32};
        vecs[8]  = '{"slt_false", OP_SLT,   32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'h0, 1'b1, 1'b0, 1,  0};
        vecs[9]  = '{"divu_100_7",OP_DIVU,  32'd100,      32'd7,        5'd0,  32'd14,       32'd2, 1'b0, 1'b0, 33, 32};
        vecs[10] = '{"divu_by0",  OP_DIVU,  32'd9,        32'd0,        5'd0,  32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 33, 32};
        vecs[11] = '{"multu_lo0", OP_MULTU, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 32'h1, 1'b1, 1'b0, 33, 32};
        vecs[12] = '{"add_wrap",  OP_ADD,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 32'h0, 1'b1, 1'b0, 1,  0};
        vecs[13] = '{"srl_4",     OP_SRL,   32'h0,        32'h12345678, 5'd4,  32'h01234567, 32'h0, 1'b0, 1'b0, 1,  0};

        rst_n = 1'b0; start = 1'b0; signal = OP_AND; dataA = '0; dataB = '0; shamt = '0;
        start8 = 1'b0; signal8 = OP_AND; dataA8 = '0; dataB8 = '0; shamt8 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dataOut", 64'(dataOut), 64'h0);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_flags", {60'h0, zero, overflow, busy, done}, 64'h0);
        check("rst8_outs", {44'h0, dataOut8, hi8, zero8, overflow8, busy8, done8}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, cyc, bcnt);
            $display("vec %0d %s: out=0x%08h hi=0x%08h z=%0b ov=%0b lat=%0d busy=%0d",
                     i, vecs[i].name, dataOut, hi, zero, overflow, cyc, bcnt);
            check({vecs[i].name, "_out"},  64'(dataOut), 64'(vecs[i].exp_out));
            check({vecs[i].name, "_hi"},   64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_zero"}, 64'(zero), 64'(vecs[i].exp_zero));
            check({vecs[i].name, "_ovf"},  64'(overflow), 64'(vecs[i].exp_ovf));
            check({vecs[i].name, "_lat"},  64'(cyc), 64'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"}, 64'(bcnt), 64'(vecs[i].exp_busy));
            @(posedge clk); #1;
            check({vecs[i].name, "_done_pulse"}, 64'(done), 64'h0);
        end

        // Reset asserted mid-MULTU, observed without a clock edge
        @(negedge clk);
        signal = OP_MULTU; dataA = 32'd3; dataB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: busy=%0b done=%0b out=0x%08h hi=0x%08h", busy, done, dataOut, hi);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        check("arst_dataOut", 64'(dataOut), 64'h0);
        check("arst_hi", 64'(hi), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 32'd3, 32'd4, 5'd0, cyc, bcnt);
        $display("post-reset add: out=%0d lat=%0d", dataOut, cyc);
        check("post_rst_add", 64'(dataOut), 64'd7);
        check("post_rst_lat", 64'(cyc), 64'd1);

        // start/op/operand changes while busy are ignored
        @(negedge clk);
        signal = OP_MULTU; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        signal = OP_ADD; dataA = 32'd5; dataB = 32'd1; start = 1'b0;
        cyc = 1;
        while (!done && cyc < MAX_CYC) begin
            start = ~start;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        $display("busy-ignore multu: out=0x%08h hi=0x%08h lat=%0d", dataOut, hi, cyc);
        check("ign_lo", 64'(dataOut), 64'h1);
        check("ign_hi", 64'(hi), 64'hFFFFFFFE);
        check("ign_lat", 64'(cyc), 64'd33);
        @(posedge clk); #1;

        // Back-to-back: second request issued in the DONE cycle
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, cyc, bcnt);
        check("b2b_first_q", 64'(dataOut), 64'd14);
        signal = OP_DIVU; dataA = 32'd9; dataB = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataA = 32'd1; dataB = 32'd1;
        check("b2b_accept_busy", 64'(busy), 64'h1);
        check("b2b_accept_done", 64'(done), 64'h0);
        t = 1;
        while (!done && t < MAX_CYC) begin
            @(posedge clk); #1;
            t++;
        end
        $display("back-to-back divu: out=0x%08h hi=%0d gap=%0d", dataOut, hi, t);
        check("b2b_gap", 64'(t), 64'd33);
        check("b2b_q", 64'(dataOut), 64'hFFFFFFFF);
        check("b2b_r", 64'(hi), 64'd9);

        // WIDTH=8 instance
        @(negedge clk);
        signal8 = OP_MULTU; dataA8 = 8'hFF; dataB8 = 8'h02; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; dataA8 = 8'h00; dataB8 = 8'h00;
        cyc = 1; bcnt = 0;
        while (!done8 && cyc < MAX_CYC) begin
            bcnt += int'(busy8);
            @(posedge clk); #1;
            cyc++;
        end
        $display("w8 multu: out=0x%02h hi=0x%02h lat=%0d busy=%0d", dataOut8, hi8, cyc, bcnt);
        check("w8_mul_lo", 64'(dataOut8), 64'hFE);
        check("w8_mul_hi", 64'(hi8), 64'h01);
        check("w8_mul_lat", 64'(cyc), 64'd9);
        check("w8_mul_busy", 64'(bcnt), 64'd8);

        @(negedge clk);
        signal8 = OP_DIVU; dataA8 = 8'd200; dataB8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < MAX_CYC) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("w8 divu: out=%0d hi=%0d lat=%0d", dataOut8, hi8, cyc);
        check("w8_div_q", 64'(dataOut8), 64'd28);
        check("w8_div_r", 64'(hi8), 64'd4);
        check("w8_div_lat", 64'(cyc), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
